seq_mul_div: RTL and testbench
==============================

Name: seq_mul_div

Overview:
- Iterative multi-cycle unsigned multiplier/divider.
- Acts as the responder on the ALU's valid/ready mul-div handshake. The ALU issues an operation with a one-cycle valid. This block computes over WIDTH cycles and returns the result with a one-cycle ready pulse.
- Product/quotient/remainder are held on out until the next accepted request.

Parameters:
WIDTH, 32, operand width; out is 2*WIDTH bits.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
valid  input  1  request strobe; sampled only when the block can accept
mode  input  1  0 = multiply, 1 = divide
in_A  input  WIDTH  multiplicand / dividend (unsigned)
in_B  input  WIDTH  multiplier / divisor (unsigned)
ready  output  1  one-cycle pulse: out holds a fresh result
busy  output  1  high while an operation is in progress
out  output  2*WIDTH  multiply: full product; divide: {remainder, quotient}

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. When rst is high at a rising edge:
  - state goes to IDLE;
  - ready=0, busy=0, out=0;
  - counter and internal registers are cleared;
  - any in-flight operation is abandoned with no ready pulse.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - valid=1 at edge E0: latch in_A, in_B and mode; counter=0; busy=1; go to MUL (mode=0) or DIV (mode=1).
  - valid=0: stay.
- MUL (shift-add, one bit per cycle):
  - Accumulator is 2*WIDTH bits.
  - Each edge: if the current multiplier LSB is 1, add the multiplicand into the upper half; then shift the accumulator right by 1 with carry-in from the adder carry; counter+1.
- DIV (restoring, one quotient bit per cycle):
  - Remainder is WIDTH+1 bits.
  - Each edge: shift {rem, dividend} left by 1; trial-subtract the divisor; if non-negative keep the difference and set the quotient bit to 1, else restore and set it to 0; counter+1.
- Iteration timing:
  - Exactly WIDTH iteration edges: E1..E_WIDTH.
  - On edge E_WIDTH: out is loaded with the final result, ready=1, busy=0, state goes to DONE.
  - Latency from accepting edge E0 to the ready-high cycle is WIDTH edges (32 at default).
- DONE (lasts one cycle, ready=1):
  - At the next edge ready returns to 0.
  - valid=1 in DONE is accepted as a new request, behaving as in IDLE (back-to-back issue). Otherwise go to IDLE.
- valid is ignored while in MUL or DIV: no queuing, no error, the current operation is unaffected.
- in_A, in_B and mode may change after the accepting edge without effect.
- out holds its value from the ready edge until the next ready edge or reset. It is not cleared when a new operation starts.
- Divide by zero (in_B=0, mode=1): runs the full WIDTH cycles, then quotient = all ones, remainder = in_A. This matches the natural restoring result; no special-case shortcut.
- All arithmetic is unsigned and modulo 2^(2*WIDTH). The multiply product never overflows 2*WIDTH bits.
- rst and valid high in the same cycle: rst wins.
- busy is combinationally equivalent to (state==MUL or state==DIV) but registered. busy=1 from the edge after E0 through the cycle before ready.

Test Plan:
- Reset, then mode=0, in_A=7, in_B=6, valid pulse -> busy=1 for 32 cycles; ready high exactly 32 edges after acceptance; out=64'd42; ready drops after 1 cycle.
- mode=0, in_A=in_B=32'hFFFFFFFF -> out=64'hFFFFFFFE_00000001.
- mode=1, in_A=100, in_B=7 -> out={32'd2, 32'd14}. Then mode=1, in_A=5, in_B=0 -> out={32'd5, 32'hFFFFFFFF}.
- During a DIV of 1000/10, pulse valid with mode=0, in_A=3, in_B=3 at cycle 10 -> ignored; single ready with out={0, 100}. Then valid in the DONE cycle with in_A=3, in_B=3, mode=0 -> accepted; ready 32 edges later with out=9.
- Start MUL 12*12, assert rst at cycle 15 -> next cycle busy=0, ready=0, out=0; no ready pulse within 40 cycles; a new request afterwards completes correctly.
- Random unsigned operands, 500 ops of both modes with random idle gaps -> out matches the reference model (product, or {A%B, A/B}); exactly one ready per accepted valid.

Source files
------------

// File: rtl/seq_mul_div_if.sv
// seq_mul_div_if: valid/ready mul-div handshake between the ALU (master) and the iterative unit (slave)
// valid/mode/in_A/in_B: request from the ALU; ready/busy/out: result side from the unit
interface seq_mul_div_if #(parameter int WIDTH = 32);
  logic valid;
  logic mode;
  logic [WIDTH-1:0] in_A;
  logic [WIDTH-1:0] in_B;
  logic ready;
  logic busy;
  logic [2*WIDTH-1:0] out;
  modport master(output valid, mode, in_A, in_B, input ready, busy, out);
  modport slave(input valid, mode, in_A, in_B, output ready, busy, out);
endinterface

// File: rtl/seq_mul_div.sv
// seq_mul_div: iterative unsigned shift-add multiplier / restoring divider, one bit per clock
// clk, rst (sync, active-high); bus.slave: valid/mode/in_A/in_B in, ready pulse/busy/out({rem,quo} or product) out
module seq_mul_div #(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic rst,
  seq_mul_div_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] op, rem, rem_n, q_n;
  logic [2*WIDTH-1:0] acc, res, mul_n;
  logic [WIDTH:0] msum, dsh, ddiff;
  logic ready, busy, accept, run, last, dok;
  assign bus.ready = ready;
  assign bus.busy = busy;
  assign bus.out = res;
  // op holds the multiplicand (mul) or divisor (div); acc low half holds multiplier / dividend-then-quotient
  always_comb begin
    accept = (state == IDLE || state == DONE) && bus.valid;
    run = state == MUL || state == DIV;
    last = cnt == CW'(WIDTH - 1);
    state_n = accept ? (bus.mode ? DIV : MUL) : run ? (last ? DONE : state) : IDLE;
    msum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, op & {WIDTH{acc[0]}}};
    mul_n = {msum, acc[WIDTH-1:1]};
    dsh = {rem, acc[WIDTH-1]};
    ddiff = dsh - {1'b0, op};
    dok = !ddiff[WIDTH];
    rem_n = dok ? ddiff[WIDTH-1:0] : dsh[WIDTH-1:0];
    q_n = {acc[WIDTH-2:0], dok};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      op <= '0;
      rem <= '0;
      acc <= '0;
      res <= '0;
      ready <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      ready <= run && last;
      busy <= accept || (run && !last);
      if (accept) begin
        cnt <= '0;
        op <= bus.mode ? bus.in_B : bus.in_A;
        acc <= {{WIDTH{1'b0}}, bus.mode ? bus.in_A : bus.in_B};
        rem <= '0;
      end else if (state == MUL) begin
        acc <= mul_n;
        cnt <= cnt + CW'(1);
        if (last) res <= mul_n;
      end else if (state == DIV) begin
        acc[WIDTH-1:0] <= q_n;
        rem <= rem_n;
        cnt <= cnt + CW'(1);
        if (last) res <= {rem_n, q_n};
      end
    end
  end
endmodule

// File: tb/tb_seq_mul_div.sv
// tb_seq_mul_div: directed and random scoreboard bench for seq_mul_div
module tb_seq_mul_div;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  seq_mul_div_if #(.WIDTH(W)) dif();
  seq_mul_div #(.WIDTH(W)) dut(.clk(clk), .rst(rst), .bus(dif.slave));
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_exp = '0;
  int tests = 0, fails = 0, rdy_cnt = 0, acc_cnt = 0;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic m, input logic [31:0] a, input logic [31:0] b);
    if (!m) return {32'd0, a} * {32'd0, b};
    if (b == 32'd0) return {a, 32'hFFFFFFFF};
    return {a % b, a / b};
  endfunction
  always @(posedge clk) begin
    #1;
    if (!rst && dif.ready) begin
      rdy_cnt++;
      check("ready_has_expect", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        last_exp = exp_q.pop_front();
        check("out", dif.out, last_exp);
      end
    end
  end
  task automatic issue(input logic m, input logic [31:0] a, input logic [31:0] b, input bit expect_accept = 1'b1);
    @(negedge clk);
    dif.valid = 1'b1;
    dif.mode = m;
    dif.in_A = a;
    dif.in_B = b;
    if (expect_accept) begin
      exp_q.push_back(model(m, a, b));
      acc_cnt++;
    end
    @(negedge clk);
    dif.valid = 1'b0;
    dif.mode = 1'($urandom);
    dif.in_A = $urandom;
    dif.in_B = $urandom;
  endtask
  task automatic wait_ready(output int n, output int bn);
    n = 0;
    bn = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (!dif.ready && dif.busy) bn++;
    end while (!dif.ready && n < 100);
    check("ready_seen", 64'(dif.ready), 64'd1);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, bn, snap;
    logic m;
    logic [31:0] a, b;
    dif.valid = 1'b0;
    dif.mode = 1'b0;
    dif.in_A = '0;
    dif.in_B = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 64'(dif.ready), 64'd0);
    check("reset_busy", 64'(dif.busy), 64'd0);
    check("reset_out", dif.out, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(1'b0, 32'd7, 32'd6);
    check("busy_after_accept", 64'(dif.busy), 64'd1);
    wait_ready(n, bn);
    check("mul_latency", 64'(n), 64'd32);
    check("busy_cycles", 64'(bn), 64'd31);
    check("busy_at_ready", 64'(dif.busy), 64'd0);
    @(posedge clk);
    #1;
    check("ready_drop", 64'(dif.ready), 64'd0);
    check("out_hold", dif.out, 64'd42);
    issue(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_ready(n, bn);
    check("mul_max_latency", 64'(n), 64'd32);
    check("mul_max_value", dif.out, 64'hFFFFFFFE_00000001);
    issue(1'b1, 32'd100, 32'd7);
    wait_ready(n, bn);
    check("div_value", dif.out, {32'd2, 32'd14});
    issue(1'b1, 32'd5, 32'd0);
    wait_ready(n, bn);
    check("div0_value", dif.out, {32'd5, 32'hFFFFFFFF});
    check("div0_latency", 64'(n), 64'd32);
    repeat (3) @(negedge clk);
    issue(1'b1, 32'd1000, 32'd10);
    repeat (8) @(negedge clk);
    issue(1'b0, 32'd3, 32'd3, 1'b0);
    wait_ready(n, bn);
    check("ignored_valid_latency", 64'(n), 64'd22);
    check("div_ignore_value", dif.out, {32'd0, 32'd100});
    issue(1'b0, 32'd3, 32'd3);
    wait_ready(n, bn);
    check("back_to_back_latency", 64'(n), 64'd32);
    check("back_to_back_value", dif.out, 64'd9);
    repeat (2) @(negedge clk);
    issue(1'b0, 32'd12, 32'd12);
    repeat (13) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    acc_cnt--;
    @(negedge clk);
    check("abort_busy", 64'(dif.busy), 64'd0);
    check("abort_ready", 64'(dif.ready), 64'd0);
    check("abort_out", dif.out, 64'd0);
    rst = 1'b0;
    snap = rdy_cnt;
    repeat (40) @(negedge clk);
    check("no_ready_after_abort", 64'(rdy_cnt), 64'(snap));
    issue(1'b0, 32'd12, 32'd12);
    wait_ready(n, bn);
    check("after_abort_latency", 64'(n), 64'd32);
    check("after_abort_value", dif.out, 64'd144);
    for (int i = 0; i < 500; i++) begin
      m = 1'($urandom);
      a = (i % 7 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      b = (i % 4 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      if ($urandom_range(0, 3) != 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      issue(m, a, b);
      wait_ready(n, bn);
      check("rand_latency", 64'(n), 64'd32);
    end
    repeat (5) @(negedge clk);
    check("out_hold_final", dif.out, last_exp);
    check("ready_count", 64'(rdy_cnt), 64'(acc_cnt));
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
